lsu_issue_queue: RTL
====================

# lsu_issue_queue

In-order load/store issue queue that sits directly upstream of the load/store unit. It accepts memory µops from dispatch and captures source operands, either at dispatch or later from the CDB. It issues the oldest µop to the LSU once its operands are ready and the LSU signals ready. It also discards wrong-path µops on a branch mispredict, using the same ROB-age rule as the LSU.

## Interface
- DATA_WIDTH, 32, operand/data width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register tag width
- DEPTH, 8, queue entries (power of two)

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- i_disp_valid  input  1  dispatch µop present
- o_disp_ready  output  1  queue can accept; = !reset && count < DEPTH
- i_disp_memwrite  input  1  1 = store, 0 = load
- i_disp_alu_op  input  4  funct3 in [2:0]; forwarded unchanged
- i_disp_imm  input  DATA_WIDTH  address offset
- i_disp_prs1 / i_disp_prs2  input  PREG_WIDTH  base / store-data source tags
- i_disp_rs1_rdy / i_disp_rs2_rdy  input  1  source value already available
- i_disp_rs1_val / i_disp_rs2_val  input  DATA_WIDTH  source values (valid when rdy)
- i_disp_prd  input  PREG_WIDTH  destination tag
- i_disp_rob_tag  input  ROB_WIDTH  ROB tag
- i_cdb_valid  input  1  CDB broadcast
- i_cdb_prd  input  PREG_WIDTH  broadcast tag
- i_cdb_data  input  DATA_WIDTH  broadcast value
- branch_mispredict  input  1  flush request
- branch_rob_tag  input  ROB_WIDTH  mispredicting branch tag
- i_lsu_ready  input  1  LSU accepts this cycle
- o_valid  output  1  head issuable
- o_base_addr, o_offset, o_store_data  output  DATA_WIDTH  rs1 value, imm, rs2 value
- o_memwrite  output  1; o_alu_op  output  4; o_prd  output  PREG_WIDTH; o_rob_tag  output  ROB_WIDTH

## Operation
- Circular buffer with head, tail and count.
  - head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Entry fields: valid, memwrite, alu_op, imm, prs1/rs1_rdy/rs1_val, prs2/rs2_rdy/rs2_val, prd, rob_tag.
- Push: when i_disp_valid && o_disp_ready && !branch_mispredict, write the entry at tail, then tail++ and count++.
  - Dispatch in a mispredict cycle is dropped.
- Wakeup: each cycle, for every valid entry with rdy=0 and prs == i_cdb_prd while i_cdb_valid, set rdy=1 and val=i_cdb_data.
  - This also applies to the µop being pushed in the same cycle. The CDB value wins over a stale dispatch value.
- Issue readiness: the head is ready when valid && rs1_rdy && (rs2_rdy || !memwrite).
- Ordering: strictly in-order. A non-ready head blocks all younger entries.
- Output fields are driven combinationally from the head entry.
  - o_valid = head ready && !(branch_mispredict && head younger).
  - Fire = o_valid && i_lsu_ready. On fire: clear the head entry, head++, count--.
- Younger test: d = tag − branch_rob_tag (mod 2^ROB_WIDTH). Younger iff d != 0 && d < 2^(ROB_WIDTH−1).
- Flush: on branch_mispredict, clear every younger entry.
  - Younger entries form a tail suffix, so tail is set to the oldest flushed slot.
  - count is set to the number of surviving entries.
  - A fire and a flush in the same cycle combine: fire applies only if the head survives.
- Simultaneous push and pop:
  - When not full, count is unchanged.
  - When full, push is refused because o_disp_ready=0. A pop that cycle does not open the slot until the next cycle.

## Timing
- Reset clears all valid bits, and sets head=tail=count=0.
  - Outputs after reset: o_valid=0, all data outputs 0, o_disp_ready=0 while reset is high and 1 afterwards.
- Dispatch to earliest issue: 1 cycle.
  - A µop pushed at edge N with ready operands can have o_valid high in cycle N+1.
- A CDB broadcast at edge N makes a dependent head issuable in cycle N+1.
- Throughput: 1 issue per cycle; 1 dispatch per cycle.
- A stalled LSU (i_lsu_ready=0) holds all outputs stable.

## Test plan
- Three loads dispatched back-to-back with ready operands (rs1_val 0x100, imm 4/8/12) and i_lsu_ready=1 -> o_valid on consecutive cycles; o_base_addr=0x100; o_offset 4, 8, 12 in order.
- Store with prs2=9 not ready, then CDB {prd=9, data=0xDEADBEEF} -> no issue until the cycle after the broadcast; o_store_data=0xDEADBEEF, o_memwrite=1.
  - A younger ready load behind it stays blocked until the store issues.
- Fill 8 entries with i_lsu_ready=0 -> o_disp_ready=0. A 9th dispatch is ignored. One fire restores o_disp_ready the next cycle.
- Queue holds tags 5, 6, 7, 8 with head 5; mispredict with branch_rob_tag=6 -> tags 7 and 8 removed and count=2; subsequent issues are 5 then 6 only.
- Wrap-around and age: ROB tags 14, 15, 0, 1 with branch_rob_tag=15 -> only 0 and 1 flushed.
  - Dispatch asserted in the mispredict cycle is dropped.
- Reset asserted mid-stream with 4 entries and the head firing -> next cycle o_valid=0, count=0, and no stale entry issues afterward.

Source files
------------

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue feeding the LSU.
// Captures source operands at dispatch or from the CDB, issues the oldest
// uop once its operands are ready, and drops wrong-path uops on a mispredict
// using the same ROB-age comparison as the LSU.
module lsu_issue_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned PREG_WIDTH = 7,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_disp_valid,
    output logic                  o_disp_ready,
    input  logic                  i_disp_memwrite,
    input  logic [3:0]            i_disp_alu_op,
    input  logic [DATA_WIDTH-1:0] i_disp_imm,
    input  logic [PREG_WIDTH-1:0] i_disp_prs1,
    input  logic [PREG_WIDTH-1:0] i_disp_prs2,
    input  logic                  i_disp_rs1_rdy,
    input  logic                  i_disp_rs2_rdy,
    input  logic [DATA_WIDTH-1:0] i_disp_rs1_val,
    input  logic [DATA_WIDTH-1:0] i_disp_rs2_val,
    input  logic [PREG_WIDTH-1:0] i_disp_prd,
    input  logic [ROB_WIDTH-1:0]  i_disp_rob_tag,
    input  logic                  i_cdb_valid,
    input  logic [PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    input  logic                  branch_mispredict,
    input  logic [ROB_WIDTH-1:0]  branch_rob_tag,
    input  logic                  i_lsu_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_base_addr,
    output logic [DATA_WIDTH-1:0] o_offset,
    output logic [DATA_WIDTH-1:0] o_store_data,
    output logic                  o_memwrite,
    output logic [3:0]            o_alu_op,
    output logic [PREG_WIDTH-1:0] o_prd,
    output logic [ROB_WIDTH-1:0]  o_rob_tag
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  valid;
        logic                  memwrite;
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] imm;
        logic [PREG_WIDTH-1:0] prs1;
        logic                  rs1_rdy;
        logic [DATA_WIDTH-1:0] rs1_val;
        logic [PREG_WIDTH-1:0] prs2;
        logic                  rs2_rdy;
        logic [DATA_WIDTH-1:0] rs2_val;
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  rob_tag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t head_ent;
    logic   head_rdy;
    logic   fire;
    logic   push;

    // Younger-than-branch test: modular distance in the ROB ring, strictly ahead.
    function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                        input logic [ROB_WIDTH-1:0] br_tag);
        logic [ROB_WIDTH-1:0] d;
        d = tag - br_tag;
        return (d != '0) && !d[ROB_WIDTH-1];
    endfunction

    // Head presentation, issue handshake and dispatch acceptance.
    always_comb begin
        head_ent     = ent_q[head_q];
        head_rdy     = head_ent.valid && head_ent.rs1_rdy
                       && (head_ent.rs2_rdy || !head_ent.memwrite);
        o_valid      = head_rdy
                       && !(branch_mispredict && is_younger(head_ent.rob_tag, branch_rob_tag));
        fire         = o_valid && i_lsu_ready;
        o_disp_ready = !reset && (count_q < CNT_W'(DEPTH));
        push         = i_disp_valid && o_disp_ready && !branch_mispredict;
        o_base_addr  = head_ent.rs1_val;
        o_offset     = head_ent.imm;
        o_store_data = head_ent.rs2_val;
        o_memwrite   = head_ent.memwrite;
        o_alu_op     = head_ent.alu_op;
        o_prd        = head_ent.prd;
        o_rob_tag    = head_ent.rob_tag;
    end

    // Next-state: CDB wakeup, push at tail, pop at head, mispredict flush.
    always_comb begin
        entry_t           new_ent;
        logic             found;
        logic [CNT_W-1:0] keep;
        logic [PTR_W-1:0] idx;

        ent_d   = ent_q;
        head_d  = head_q + PTR_W'(fire);
        tail_d  = tail_q;
        count_d = count_q;
        new_ent = '0;
        found   = 1'b0;
        keep    = count_q;
        idx     = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].rs1_rdy && ent_q[i].prs1 == i_cdb_prd) begin
                    ent_d[i].rs1_rdy = 1'b1;
                    ent_d[i].rs1_val = i_cdb_data;
                end
                if (!ent_q[i].rs2_rdy && ent_q[i].prs2 == i_cdb_prd) begin
                    ent_d[i].rs2_rdy = 1'b1;
                    ent_d[i].rs2_val = i_cdb_data;
                end
            end
        end

        if (push) begin
            new_ent.valid    = 1'b1;
            new_ent.memwrite = i_disp_memwrite;
            new_ent.alu_op   = i_disp_alu_op;
            new_ent.imm      = i_disp_imm;
            new_ent.prs1     = i_disp_prs1;
            new_ent.rs1_rdy  = i_disp_rs1_rdy;
            new_ent.rs1_val  = i_disp_rs1_val;
            new_ent.prs2     = i_disp_prs2;
            new_ent.rs2_rdy  = i_disp_rs2_rdy;
            new_ent.rs2_val  = i_disp_rs2_val;
            new_ent.prd      = i_disp_prd;
            new_ent.rob_tag  = i_disp_rob_tag;
            // A same-cycle broadcast overrides whatever value dispatch carried.
            if (i_cdb_valid && !i_disp_rs1_rdy && i_disp_prs1 == i_cdb_prd) begin
                new_ent.rs1_rdy = 1'b1;
                new_ent.rs1_val = i_cdb_data;
            end
            if (i_cdb_valid && !i_disp_rs2_rdy && i_disp_prs2 == i_cdb_prd) begin
                new_ent.rs2_rdy = 1'b1;
                new_ent.rs2_val = i_cdb_data;
            end
            ent_d[tail_q] = new_ent;
        end

        if (fire) begin
            ent_d[head_q] = '0;
        end

        if (branch_mispredict) begin
            // Younger entries are a tail suffix: the first younger slot found
            // walking from head is where tail rewinds to, and its offset is the
            // number of survivors (before any pop this cycle).
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_q + PTR_W'(i);
                if (!found && (CNT_W'(i) < count_q)
                    && is_younger(ent_q[idx].rob_tag, branch_rob_tag)) begin
                    found = 1'b1;
                    keep  = CNT_W'(i);
                end
                if (ent_q[i].valid && is_younger(ent_q[i].rob_tag, branch_rob_tag)) begin
                    ent_d[i] = '0;
                end
            end
            tail_d  = head_q + keep[PTR_W-1:0];
            count_d = keep - CNT_W'(fire);
        end else begin
            tail_d  = tail_q + PTR_W'(push);
            count_d = count_q + CNT_W'(push) - CNT_W'(fire);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
